spi_master_byte: RTL and testbench
==================================

# spi_master_byte

SPI mode 3 (CPOL=1, CPHA=1) master that transfers one byte per request, MSB first, full duplex. It drives SCLK, MOSI and SS toward an off-chip or on-board SPI slave byte interface and samples MISO. All logic runs on sysClk. The user side is a start/busy handshake with a one-cycle rxValid pulse, and SS can optionally be held across bytes for multi-byte messages.

## Interface
- CLK_DIV, 4: sysClk cycles per SCLK half-period; legal values ≥ 4.
- SS_LEAD, 8: cycles SS is low before the first SCLK falling edge; ≥ 1.
- SS_LAG, 8: cycles SS stays low after the last SCLK rising edge; ≥ 1.
- SS_GAP, 8: minimum cycles SS stays high between messages; ≥ 1.
- sysClk  in  1  system clock; the block's only clock.
- usrReset  in  1  synchronous, active-high reset.
- start  in  1  request a byte transfer; honoured only when busy=0.
- tx  in  8  byte to send; latched in the cycle start is accepted.
- keepSS  in  1  sampled at byte end: 1 keeps SS low for a further byte.
- busy  out  1  high while a transfer, lag or gap is in progress.
- rxValid  out  1  one-cycle pulse; rx holds a new byte.
- rx  out  8  byte received on MISO; held until the next rxValid.
- SCLK  out  1  SPI clock; idles high.
- MOSI  out  1  master out, slave in.
- MISO  in  1  slave out, master in; asynchronous input.
- SS  out  1  slave select, active low.

## Operation
- States: IDLE, LEAD, XFER, HOLD, LAG, GAP.
- All outputs are registered.
- Reset values: SCLK=1, SS=1, MOSI=1, busy=0, rxValid=0, rx=8'h00; state IDLE, all counters 0.
- A reset asserted mid-transfer aborts the transfer; no rxValid is generated.
- MISO passes through a 2-flop synchronizer before use.
- **IDLE**: on start=1, latch tx into the shift register and go to LEAD. Outputs SS=0, busy=1.
- **LEAD**: hold SCLK=1 for SS_LEAD cycles, then go to XFER.
- **XFER**: 16 half-periods h=0..15, each CLK_DIV cycles long.
  - Even h: SCLK=0. The falling edge at the start of the half drives MOSI = shift bit 7−h/2.
  - Odd h: SCLK=1.
  - In the last cycle of each odd half, shift the synchronized MISO into the receive register, LSB in.
  - After h=15: load rx from the receive register, pulse rxValid once, and sample keepSS. keepSS=1 goes to HOLD; keepSS=0 goes to LAG.
- **HOLD**: SS=0, SCLK=1, busy=0.
  - start=1: latch tx and go directly to XFER with no lead time.
  - Else keepSS=0: go to LAG (busy=1).
  - If start and keepSS=0 occur together, start wins.
- **LAG**: SS=0 for SS_LAG cycles. Then SS=1 and go to GAP.
- **GAP**: SS=1 for SS_GAP cycles with busy=1, then go to IDLE (busy=0).
- start while busy=1 is ignored, with no queuing.
- MOSI returns to 1 when SS rises. MOSI holds its last bit in HOLD.

## Timing
- start accepted at cycle N: SS=0 and busy=1 visible at N+1.
- First SCLK falling edge at N+1+SS_LEAD.
- rxValid=1 and new rx at N+1+SS_LEAD+16·CLK_DIV, for exactly 1 cycle.
- SCLK period is 2·CLK_DIV. There are exactly 8 falling and 8 rising edges per byte, and SCLK ends high.
- MISO sample point: MISO has 2·CLK_DIV−2 cycles after the falling edge to settle, before synchronizer delay.
- Non-HOLD path: SS rises at the rxValid cycle + SS_LAG. busy falls SS_GAP cycles after SS rises.
- Back-to-back with keepSS=1 and start asserted at the rxValid cycle + 1: next falling edge is 1 cycle after start. SS never rises between the bytes.

## Test plan
- Defaults, tx=8'hA5, MISO looped to MOSI:
  - rx=8'hA5 with rxValid at N+1+8+64=N+73.
  - 8 rising SCLK edges, period 8 cycles.
  - MOSI bits 1,0,1,0,0,1,0,1.
- Mode 3 slave behavioural model returning 8'h3C while master sends 8'h81:
  - rx=8'h3C.
  - The model receives 8'h81.
- keepSS=1, two bytes 8'h12 then 8'h34, slave echo:
  - SS low continuously from first start to the end of LAG.
  - rxValid twice, with rx=8'h12 then rx=8'h34.
- start pulsed during XFER and during GAP:
  - Ignored; exactly one byte on the wire.
  - busy falls SS_GAP cycles after SS rises.
- usrReset asserted at h=7 of XFER:
  - Next cycle SCLK=1, SS=1, MOSI=1, busy=0, rxValid=0.
  - A new start completes a normal transfer.
- MISO held 1, then held 0:
  - rx=8'hFF, then 8'h00.
  - Repeat with CLK_DIV=4 and CLK_DIV=6 to check the half-period count.

Source files
------------

// File: rtl/spi_master_byte.sv
// SPI mode 3 byte master: MSB first, full duplex, with optional SS hold
// across bytes for multi-byte messages.
module spi_master_byte #(
  parameter int CLK_DIV = 4,
  parameter int SS_LEAD = 8,
  parameter int SS_LAG  = 8,
  parameter int SS_GAP  = 8
) (
  input  logic       sysClk,
  input  logic       usrReset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       keepSS,
  output logic       busy,
  output logic       rxValid,
  output logic [7:0] rx,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

  typedef enum logic [2:0] {
    IDLE, LEAD, XFER, HOLD, LAG, GAP
  } state_e;

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LEAD_M1 = 16'(SS_LEAD - 1);
  localparam logic [15:0] LAG_M1  = 16'(SS_LAG - 1);
  localparam logic [15:0] GAP_M1  = 16'(SS_GAP - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  half_q, half_d;
  logic [7:0]  txsh_q, txsh_d;
  logic [7:0]  rxsh_q, rxsh_d;
  logic [7:0]  rx_q, rx_d;
  logic        rxv_q, rxv_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic        busy_q, busy_d;
  logic        miso_meta_q, miso_sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    txsh_d  = txsh_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    rxv_d   = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          txsh_d  = tx;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_q == LEAD_M1) begin
          cnt_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          mosi_d  = txsh_q[7];
          txsh_d  = {txsh_q[6:0], 1'b0};
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      XFER: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (half_q[0]) begin
            rxsh_d = {rxsh_q[6:0], miso_sync_q};
          end
          if (half_q == 4'd15) begin
            rx_d  = {rxsh_q[6:0], miso_sync_q};
            rxv_d = 1'b1;
            if (keepSS) begin
              busy_d  = 1'b0;
              state_d = HOLD;
            end else begin
              state_d = LAG;
            end
          end else begin
            half_d = half_q + 4'd1;
            // entering an even half: falling edge launches the next bit
            if (half_q[0]) begin
              sclk_d = 1'b0;
              mosi_d = txsh_q[7];
              txsh_d = {txsh_q[6:0], 1'b0};
            end else begin
              sclk_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (start) begin
          txsh_d  = {tx[6:0], 1'b0};
          mosi_d  = tx[7];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          half_d  = '0;
          state_d = XFER;
        end else if (!keepSS) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = LAG;
        end
      end
      LAG: begin
        if (cnt_q == LAG_M1) begin
          ss_d    = 1'b1;
          mosi_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_M1) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      txsh_q      <= '0;
      rxsh_q      <= '0;
      rx_q        <= '0;
      rxv_q       <= 1'b0;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b1;
      ss_q        <= 1'b1;
      busy_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      txsh_q      <= txsh_d;
      rxsh_q      <= rxsh_d;
      rx_q        <= rx_d;
      rxv_q       <= rxv_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      busy_q      <= busy_d;
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign busy    = busy_q;
  assign rxValid = rxv_q;
  assign rx      = rx_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: CLK_DIV=4 and CLK_DIV=6 instances,
// table of single-byte transfers plus keepSS and reset sequences.
module tb_spi_master_byte;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] mode;
    logic       sel;
    logic       inject;
    logic [7:0] exp_rx;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       usr_reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx = 8'h00;
  logic       keep = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       busy0, rxv0, sclk0, mosi0, ss0, miso0;
  logic       busy1, rxv1, sclk1, mosi1, ss1, miso1;
  logic [7:0] rx0, rx1;

  logic       slave_miso = 1'b1;
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] slave_rx = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  assign miso0 = (mode == 2'd0) ? mosi0 :
                 (mode == 2'd1) ? slave_miso :
                 (mode == 2'd2);
  assign miso1 = (mode == 2'd0) ? mosi1 : (mode == 2'd2);

  spi_master_byte dut0 (
    .sysClk(clk), .usrReset(usr_reset),
    .start(start & ~sel), .tx(tx), .keepSS(keep),
    .busy(busy0), .rxValid(rxv0), .rx(rx0),
    .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0), .SS(ss0)
  );

  spi_master_byte #(.CLK_DIV(6)) dut1 (
    .sysClk(clk), .usrReset(usr_reset),
    .start(start & sel), .tx(tx), .keepSS(keep),
    .busy(busy1), .rxValid(rxv1), .rx(rx1),
    .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .SS(ss1)
  );

  wire       busy_s = sel ? busy1 : busy0;
  wire       rxv_s  = sel ? rxv1 : rxv0;
  wire [7:0] rx_s   = sel ? rx1 : rx0;
  wire       sclk_s = sel ? sclk1 : sclk0;
  wire       mosi_s = sel ? mosi1 : mosi0;
  wire       ss_s   = sel ? ss1 : ss0;

  // mode 3 slave: shift out on falling SCLK, capture on rising
  always @(negedge sclk0) begin
    if (ss0 == 1'b0) begin
      slave_miso <= slave_sh[7];
      slave_sh   <= {slave_sh[6:0], 1'b0};
    end
  end
  always @(posedge sclk0) begin
    if (ss0 == 1'b0) slave_rx <= {slave_rx[6:0], mosi0};
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_byte(input vec_t v);
    int cd, rises, falls, nval, first_fall;
    int t_val, t_ss, t_busy, last_rise, bad_per, ss_lo;
    logic [7:0] mbits, rx_seen;
    logic prev;
    cd = v.sel ? 6 : 4;
    sel = v.sel;
    mode = v.mode;
    slave_sh = 8'h3C;
    slave_rx = 8'h00;
    tx = v.tx;
    keep = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ss_low_n1", ss_s, 0);
    check("busy_n1", busy_s, 1);
    prev = 1'b1;
    rises = 0; falls = 0; nval = 0; first_fall = -1;
    t_val = -1; t_ss = -1; t_busy = -1; last_rise = -1; bad_per = 0;
    mbits = 8'h00; rx_seen = 8'h00;
    for (int k = 1; k < 400; k++) begin
      if (k > 1) tick();
      start = v.inject && (k == 20 || (t_ss >= 0 && k == t_ss + 3));
      if (prev && !sclk_s) begin
        falls++;
        if (first_fall < 0) first_fall = k;
      end
      if (!prev && sclk_s) begin
        if (last_rise >= 0 && k - last_rise != 2 * cd) bad_per++;
        rises++;
        last_rise = k;
        mbits = {mbits[6:0], mosi_s};
      end
      prev = sclk_s;
      if (rxv_s) begin
        nval++;
        t_val = k;
        rx_seen = rx_s;
      end
      if (t_ss < 0 && ss_s) t_ss = k;
      if (t_ss >= 0 && !busy_s) begin
        t_busy = k;
        break;
      end
    end
    start = 1'b0;
    check("done_in_budget", int'(t_busy >= 0), 1);
    check("rx", rx_seen, v.exp_rx);
    check("rx_latency", t_val, 9 + 16 * cd);
    check("rxvalid_count", nval, 1);
    check("first_fall", first_fall, 9);
    check("falls", falls, 8);
    check("rises", rises, 8);
    check("bad_periods", bad_per, 0);
    check("mosi_bits", mbits, v.tx);
    check("sclk_ends_high", sclk_s, 1);
    check("ss_lag", t_ss - t_val, 8);
    check("ss_gap", t_busy - t_ss, 8);
    if (v.mode == 2'd1) check("slave_rx", slave_rx, v.tx);
    ss_lo = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (!ss_s || busy_s) ss_lo++;
    end
    check("idle_after", ss_lo, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int cnt, ss_hi;
    logic got;
    vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h81, 2'd1, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, 2'd2, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'hFF, 2'd3, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{8'h96, 2'd0, 1'b0, 1'b1, 8'h96};
    vecs[5] = '{8'h5A, 2'd2, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{8'hC3, 2'd3, 1'b1, 1'b0, 8'h00};

    repeat (3) tick();
    check("rst_sclk0", sclk0, 1);
    check("rst_ss0", ss0, 1);
    check("rst_mosi0", mosi0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_rxv0", rxv0, 0);
    check("rst_rx0", rx0, 0);
    check("rst_sclk1", sclk1, 1);
    check("rst_ss1", ss1, 1);
    usr_reset = 1'b0;
    tick();

    foreach (vecs[i]) run_byte(vecs[i]);

    // CLK_DIV=6 loopback as well
    begin
      vec_t v6;
      v6 = '{8'hC3, 2'd0, 1'b1, 1'b0, 8'hC3};
      run_byte(v6);
    end

    // two bytes with SS held
    sel = 1'b0; mode = 2'd0;
    tx = 8'h12; keep = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ss_hi = 0; got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (ss0) ss_hi++;
      if (rxv0) begin got = 1'b1; break; end
      tick();
    end
    check("kss_rxv1_seen", got, 1);
    check("kss_rx1", rx0, 8'h12);
    check("kss_hold_busy", busy0, 0);
    tick();
    check("kss_hold_ss", ss0, 0);
    tx = 8'h34; keep = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("kss_fall_next", sclk0, 0);
    check("kss_busy2", busy0, 1);
    check("kss_mosi_b7", mosi0, 0);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (ss0) ss_hi++;
      if (rxv0) begin got = 1'b1; break; end
      tick();
    end
    check("kss_rxv2_seen", got, 1);
    check("kss_rx2", rx0, 8'h34);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      cnt++;
      if (ss0) break;
      if (!busy0) ss_hi++;
    end
    check("kss_lag", cnt, 8);
    check("kss_ss_never_high", ss_hi, 0);
    repeat (12) tick();
    check("kss_idle", busy0, 0);

    // reset during half 7 of XFER
    tx = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (37) tick();
    check("mid_sclk_h7", sclk0, 1);
    usr_reset = 1'b1;
    tick();
    usr_reset = 1'b0;
    check("abort_sclk", sclk0, 1);
    check("abort_ss", ss0, 1);
    check("abort_mosi", mosi0, 1);
    check("abort_busy", busy0, 0);
    check("abort_rxv", rxv0, 0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (rxv0 || busy0 || !ss0) cnt++;
    end
    check("abort_quiet", cnt, 0);
    run_byte(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
